// File: rtl/seg_scan_pkg.sv
// Shared glyph constants, converter state encoding and decode helpers for seg_scan_display.
package seg_scan_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } conv_state_t;

  function automatic logic [6:0] nibble_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg_scan_display_bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble converter, one value bit per SHIFT cycle,
// with a registered BCD/overflow result updated in the DONE state.
module bin2bcd_seq
  import seg_scan_pkg::*;
#(
  parameter int VAL_W    = 7,
  parameter int N_DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [VAL_W-1:0]      value,
  input  logic                  load,
  output logic                  busy,
  output logic [4*N_DIGITS-1:0] bcd,
  output logic                  ovf
);

  localparam int          BCD_W     = 4 * N_DIGITS;
  localparam int          CNT_W     = $clog2(VAL_W + 1);
  localparam logic [63:0] MAX_SHOWN = pow10(N_DIGITS) - 64'd1;

  conv_state_t      state;
  conv_state_t      state_nx;
  logic [VAL_W-1:0] shreg;
  logic [BCD_W-1:0] acc;
  logic [BCD_W-1:0] acc_adj;
  logic [CNT_W-1:0] bit_cnt;
  logic             ovf_pend;

  assign busy = (state != ST_IDLE);

  // Next-state logic of the conversion FSM
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (load) state_nx = ST_SHIFT;
        else      state_nx = ST_IDLE;
      end
      ST_SHIFT: begin
        if (bit_cnt == CNT_W'(VAL_W - 1)) state_nx = ST_DONE;
        else                              state_nx = ST_SHIFT;
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Add-3 correction of every BCD nibble that would overflow on the next shift
  always_comb begin
    acc_adj = acc;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (acc[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
      else                       acc_adj[4*i +: 4] = acc[4*i +: 4];
    end
  end

  // Conversion datapath and result register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      shreg    <= '0;
      acc      <= '0;
      bit_cnt  <= '0;
      ovf_pend <= 1'b0;
      bcd      <= '0;
      ovf      <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        ST_IDLE: begin
          if (load) begin
            shreg    <= value;
            acc      <= '0;
            bit_cnt  <= '0;
            ovf_pend <= (64'(value) > MAX_SHOWN);
          end
        end
        ST_SHIFT: begin
          // carry out of the top digit is dropped; it only happens on overflow
          {acc, shreg} <= {acc_adj[BCD_W-2:0], shreg, 1'b0};
          bit_cnt      <= bit_cnt + CNT_W'(1);
        end
        ST_DONE: begin
          bcd <= acc;
          ovf <= ovf_pend;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/seg_scan_display.sv
// Multiplexed seven-segment driver: converts a binary value to BCD and scans it across N_DIGITS.
// Optional leading-zero blanking is enabled with `define SEG_SCAN_LEADING_BLANK_EN.
module seg_scan_display
  import seg_scan_pkg::*;
#(
  parameter int VAL_W       = 7,
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_CNT = 100000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [VAL_W-1:0]    value,
  input  logic                load,
  output logic                busy,
  output logic [N_DIGITS-1:0] Anode,
  output logic [6:0]          LED
);

  localparam int                  RC_W      = $clog2(REFRESH_CNT);
  localparam int                  IDX_W     = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [N_DIGITS-1:0] ANODE_RST = ~N_DIGITS'(1);

  logic [4*N_DIGITS-1:0] bcd;
  logic                  ovf;
  logic [RC_W-1:0]       refresh_cnt;
  logic [IDX_W-1:0]      digit_idx;
  logic [3:0]            cur_nib;
  logic                  blank;
  logic [N_DIGITS-1:0]   anode_nx;
  logic [6:0]            seg_nx;

  bin2bcd_seq #(
    .VAL_W    (VAL_W),
    .N_DIGITS (N_DIGITS)
  ) u_conv (
    .clk   (clk),
    .rst   (rst),
    .value (value),
    .load  (load),
    .busy  (busy),
    .bcd   (bcd),
    .ovf   (ovf)
  );

  // Refresh counter and digit index, free-running regardless of conversions
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refresh_cnt <= '0;
      digit_idx   <= '0;
    end else if (refresh_cnt == RC_W'(REFRESH_CNT - 1)) begin
      refresh_cnt <= '0;
      if (digit_idx == IDX_W'(N_DIGITS - 1)) digit_idx <= '0;
      else                                   digit_idx <= digit_idx + IDX_W'(1);
    end else begin
      refresh_cnt <= refresh_cnt + RC_W'(1);
    end
  end

  assign cur_nib = bcd[{digit_idx, 2'b00} +: 4];

`ifdef SEG_SCAN_LEADING_BLANK_EN
  logic [N_DIGITS-1:0] upper_zero;

  // upper_zero[d]: digit d and every digit above it are zero
  always_comb begin
    logic zero_run;
    zero_run   = 1'b1;
    upper_zero = '0;
    for (int d = N_DIGITS - 1; d >= 0; d--) begin
      zero_run      = zero_run && (bcd[4*d +: 4] == 4'd0);
      upper_zero[d] = zero_run;
    end
  end

  assign blank = (digit_idx != '0) && upper_zero[digit_idx];
`else
  assign blank = 1'b0;
`endif

  // Select the anode and glyph for the current digit
  always_comb begin
    anode_nx            = '1;
    anode_nx[digit_idx] = 1'b0;
    if (ovf)        seg_nx = SEG_DASH;
    else if (blank) seg_nx = SEG_BLANK;
    else            seg_nx = nibble_to_seg(cur_nib);
  end

  // Anode and segments are registered together so digits switch without ghosting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Anode <= ANODE_RST;
      LED   <= SEG_0;
    end else begin
      Anode <= anode_nx;
      LED   <= seg_nx;
    end
  end

endmodule
